// File: rtl/bg1_2_fetch.sv
// bg1_2_fetch: scrolled 2x-upscaled background address gen, ROM read and sync-aligned palette index
module bg1_2_fetch #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              hs,
  input  logic              vs,
  input  logic [7:0]        scroll_y,
  input  logic              scroll_we,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_q,
  output logic [4:0]        pal_index,
  output logic              blank_o,
  output logic              hs_o,
  output logic              vs_o
);
  logic [7:0]        scroll_pend, scroll_act, fold;
  logic              vs_prev, frame_edge, active, act_d1, act_d2;
  logic [9:0]        col, row_sum, row;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        blank_sr, hs_sr, vs_sr;

  always_comb begin
    fold       = scroll_y >= 8'(IMG_H) ? scroll_y - 8'(IMG_H) : scroll_y;
    frame_edge = !vs && vs_prev;
    active     = (DrawX < 10'(2 * IMG_W)) && (DrawY < 10'(2 * IMG_H));
    col        = DrawX >> 1;
    row_sum    = (DrawY >> 1) + 10'(scroll_act);
    // both terms are below IMG_H inside the active area, so one wrap is enough
    row        = row_sum >= 10'(IMG_H) ? row_sum - 10'(IMG_H) : row_sum;
    addr       = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      scroll_pend <= '0;
      scroll_act  <= '0;
      vs_prev     <= 1'b1;
      rom_addr    <= '0;
      act_d1      <= 1'b0;
      act_d2      <= 1'b0;
      pal_index   <= '0;
      blank_sr    <= '0;
      hs_sr       <= '1;
      vs_sr       <= '1;
    end else begin
      if (scroll_we) scroll_pend <= fold;
      // latch scroll only at vsync fall so a frame never tears
      if (frame_edge) scroll_act <= scroll_we ? fold : scroll_pend;
      vs_prev   <= vs;
      rom_addr  <= active ? addr : '0;
      act_d1    <= active;
      act_d2    <= act_d1;
      pal_index <= act_d2 ? rom_q : 5'd0;
      blank_sr  <= {blank_sr[1:0], blank};
      hs_sr     <= {hs_sr[1:0], hs};
      vs_sr     <= {vs_sr[1:0], vs};
    end
  end

  assign blank_o = blank_sr[2];
  assign hs_o    = hs_sr[2];
  assign vs_o    = vs_sr[2];
endmodule

// File: tb/tb_bg1_2_fetch.sv
// tb_bg1_2_fetch: directed and random checks of bg1_2_fetch against a per-pixel reference model
module tb_bg1_2_fetch;
  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        blank = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [7:0]  scroll_y = '0;
  logic        scroll_we = 1'b0;
  logic [16:0] rom_addr;
  logic [4:0]  rom_q = '0;
  logic [4:0]  pal_index;
  logic        blank_o, hs_o, vs_o;

  int n_chk = 0, n_fail = 0;
  int k = 10;
  int s_act = 0, s_pend = 0;
  bit vs_p = 1'b1;
  int rec_addr[8192];
  bit rec_act[8192], rec_bl[8192], rec_hs[8192], rec_vs[8192], rec_rst[8192];

  bg1_2_fetch dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .hs(hs), .vs(vs), .scroll_y(scroll_y), .scroll_we(scroll_we),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .blank_o(blank_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [4:0] rom_f(input int a);
    return 5'((a ^ (a >> 5) ^ (a >> 11)) & 31);
  endfunction

  always @(posedge vga_clk) rom_q <= rom_f(int'(rom_addr));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input int x, input int y, input bit bl, input bit h,
                      input bit v, input int sy, input bit we);
    int k0, k1, k2;
    bit dark;
    reset = r; DrawX = 10'(x); DrawY = 10'(y); blank = bl; hs = h; vs = v;
    scroll_y = 8'(sy); scroll_we = we;
    k++;
    k0 = k % 8192; k1 = (k - 1) % 8192; k2 = (k - 2) % 8192;
    rec_rst[k0] = r;
    rec_act[k0] = !r && x < 640 && y < 480;
    rec_addr[k0] = rec_act[k0] ? (((y / 2) + s_act) % 240) * 320 + x / 2 : 0;
    rec_bl[k0] = r ? 1'b0 : bl;
    rec_hs[k0] = r ? 1'b1 : h;
    rec_vs[k0] = r ? 1'b1 : v;
    if (r) begin
      s_act = 0; s_pend = 0; vs_p = 1'b1;
    end else begin
      if (!v && vs_p) s_act = we ? sy % 240 : s_pend;
      if (we) s_pend = sy % 240;
      vs_p = v;
    end
    @(posedge vga_clk);
    @(negedge vga_clk);
    dark = r || rec_rst[k1];
    chk("rom_addr", int'(rom_addr), rec_addr[k0]);
    chk("pal_index", int'(pal_index), (dark || !rec_act[k2]) ? 0 : int'(rom_f(rec_addr[k2])));
    chk("blank_o", int'(blank_o), dark ? 0 : int'(rec_bl[k2]));
    chk("hs_o", int'(hs_o), dark ? 1 : int'(rec_hs[k2]));
    chk("vs_o", int'(vs_o), dark ? 1 : int'(rec_vs[k2]));
  endtask

  initial begin
    bit rv = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      rec_rst[i] = 1'b1; rec_act[i] = 1'b0; rec_addr[i] = 0;
      rec_bl[i] = 1'b0; rec_hs[i] = 1'b1; rec_vs[i] = 1'b1;
    end
    @(negedge vga_clk);
    repeat (3) step(1, 0, 0, 0, 1, 1, 0, 0);
    chk("reset_blank_o", int'(blank_o), 0);
    step(0, 0, 0, 1, 0, 1, 0, 0);
    chk("addr_origin", int'(rom_addr), 0);
    repeat (3) step(0, 2, 0, 1, 1, 1, 0, 0);
    step(0, 639, 479, 1, 1, 1, 0, 0);
    chk("addr_max", int'(rom_addr), 76799);
    step(0, 640, 479, 0, 1, 1, 0, 0);
    chk("addr_offscreen", int'(rom_addr), 0);
    repeat (3) step(0, 700, 479, 0, 1, 1, 0, 0);
    chk("pal_offscreen", int'(pal_index), 0);
    step(0, 100, 100, 1, 1, 1, 10, 1);
    step(0, 0, 0, 1, 1, 1, 0, 0);
    chk("scroll_pending", int'(rom_addr), 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    chk("scroll10_row0", int'(rom_addr), 3200);
    step(0, 0, 460, 1, 1, 0, 0, 0);
    chk("scroll10_wrap", int'(rom_addr), 0);
    step(0, 0, 0, 1, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 250, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    chk("scroll250_row0", int'(rom_addr), 3200);
    step(0, 0, 460, 1, 1, 0, 0, 0);
    chk("scroll250_wrap", int'(rom_addr), 0);
    step(0, 0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 5, 1);
    step(0, 2, 0, 1, 1, 0, 0, 0);
    chk("coincident_we", int'(rom_addr), 1601);
    step(0, 300, 200, 1, 0, 0, 0, 0);
    step(0, 302, 200, 1, 0, 0, 0, 0);
    step(1, 304, 200, 1, 0, 0, 0, 0);
    chk("rst_pal", int'(pal_index), 0);
    chk("rst_blank", int'(blank_o), 0);
    chk("rst_hs", int'(hs_o), 1);
    chk("rst_vs", int'(vs_o), 1);
    repeat (4) step(0, 306, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int x, y;
      x = $urandom_range(0, 799);
      y = $urandom_range(0, 524);
      if ($urandom_range(0, 40) == 0) rv = ~rv;
      step($urandom_range(0, 400) == 0, x, y, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, rv, $urandom_range(0, 255), $urandom_range(0, 15) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bg1_2_fetch.md
# bg1_2_fetch

Background pixel-fetch stage for the bg1_2 layer. Takes the VGA controller's raster position and sync signals, computes the address of the 2x-upscaled, vertically scrollable 320x240 background image, reads the synchronous bg1_2 index ROM, and emits a 5-bit palette index with blank and sync delayed to match. Its output index drives the bg1_2 palette lookup directly, and its delayed syncs go to the VGA pins alongside that lookup's RGB.

## Interface
Parameters:
- IMG_W, 320, stored image width in pixels (screen width / 2)
- IMG_H, 240, stored image height in rows (screen height / 2)
- ADDR_W, 17, ROM address width (ceil(log2(IMG_W*IMG_H)))

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- DrawX  in  10  raster column, 0..799
- DrawY  in  10  raster row, 0..524
- blank  in  1  active-low: 0 = blanking interval
- hs  in  1  hsync from VGA controller, active-low
- vs  in  1  vsync from VGA controller, active-low
- scroll_y  in  8  requested vertical scroll in image rows
- scroll_we  in  1  one-cycle write strobe for scroll_y
- rom_addr  out  ADDR_W  registered address to the synchronous index ROM
- rom_q  in  5  ROM data; valid one cycle after rom_addr is registered
- pal_index  out  5  registered palette index to the palette lookup
- blank_o  out  1  blank delayed 3 cycles
- hs_o  out  1  hs delayed 3 cycles
- vs_o  out  1  vs delayed 3 cycles

## Operation
- Scroll registers: scroll_pend and scroll_act, both 8-bit.
  - On scroll_we, scroll_pend <= scroll_y, folded mod 240. Values 240..255 become value-240.
  - Frame boundary is the cycle where vs is 0 and the previous-cycle vs was 1 (vsync falling edge).
  - At the frame boundary, scroll_act <= scroll_pend.
  - If scroll_we coincides with the boundary, scroll_act takes the folded new scroll_y directly, and scroll_pend also takes it.
  - scroll_act never changes mid-frame, so there is no tearing.
- Address computation (stage 1, registered into rom_addr):
  - col = DrawX>>1
  - row = (DrawY>>1) + scroll_act. If row ≥ IMG_H, subtract IMG_H. A single subtraction suffices because both operands are < 240.
  - rom_addr = row*IMG_W + col. The multiply is row<<8 + row<<6, computed at ADDR_W bits with no overflow (max 76799).
  - Outside the active area (DrawX ≥ 640 or DrawY ≥ 480), rom_addr = 0 and an internal act_d1 flag = 0. Otherwise act_d1 = 1.
- Stage 2: the ROM registers rom_addr internally and presents rom_q. act_d1 is delayed to act_d2.
- Stage 3: pal_index <= act_d2 ? rom_q : 5'd0.
- Sideband: blank, hs and vs pass through a 3-stage shift register, so they stay aligned with pal_index.
- No stalls and no backpressure: the pipeline advances every vga_clk cycle.

## Timing
- Latency: DrawX/DrawY/blank/hs/vs sampled at edge N. rom_addr updates at edge N+1, rom_q is valid after edge N+2, and pal_index, blank_o, hs_o and vs_o update at edge N+3.
- Throughput: one pixel per cycle.
- The scroll value used for a pixel is the scroll_act value sampled at edge N.
- Frame-boundary edge detect uses a vs_prev register, which resets to 1.
- Reset values (asserted at any edge, takes effect that edge, mid-line or mid-frame):
  - rom_addr = 0, pal_index = 0
  - blank_o = 0 (blanked)
  - hs_o = 1, vs_o = 1 (inactive)
  - all delay stages = blanked/inactive
  - scroll_pend = 0, scroll_act = 0, vs_prev = 1, act_d1 = act_d2 = 0
- After reset is released, the first 3 output cycles show blanked/inactive values.
- A vsync falling edge during reset is not registered as a frame boundary.

## Test plan
- Reset, then DrawX=0, DrawY=0, scroll 0 -> rom_addr=0 at N+1; pal_index = rom_q(0) at N+3; blank_o/hs_o/vs_o equal the inputs from N.
- Scroll 0, DrawX=639, DrawY=479 -> rom_addr = 239*320+319 = 76799. Then DrawX=640 -> rom_addr=0 and pal_index=0 three cycles later.
- scroll_y=10 written mid-frame -> rom_addr unchanged until the vs falling edge. From the next frame, DrawY=0 gives row 10 (addr 3200), and DrawY=460 gives row 230+10-240=0 (addr 0).
- scroll_y=250 written -> folds to 10; same addresses as the previous scenario.
- scroll_we=1 with scroll_y=5 on the exact vs-falling cycle -> scroll_act=5 immediately; DrawY=0, DrawX=2 at the next sample gives addr 1601.
- Reset asserted mid-line with active pixels in flight -> the next cycle shows pal_index=0, blank_o=0, hs_o=vs_o=1, scroll_act=0. Outputs resume 3 cycles after release.
